// File: rtl/rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rx_fifo_pkg
// Brief    : Shared defaults and derived widths for the SSP receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package rx_fifo_pkg;

  localparam int RX_FIFO_WIDTH = 8;
  localparam int RX_FIFO_DEPTH = 4;
  localparam int RX_FIFO_PTR_W = $clog2(RX_FIFO_DEPTH);
  localparam int RX_FIFO_CNT_W = RX_FIFO_PTR_W + 1;

  function automatic int rx_fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_fifo_if
// Brief    : APB read port plus SSP receive push port of the receive FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface rx_fifo_if
  import rx_fifo_pkg::*;
#(
  parameter int WIDTH = RX_FIFO_WIDTH
);

  logic             PSEL_RX;
  logic             PWRITE_RX;
  logic [WIDTH-1:0] PRDATA_RX;
  logic [WIDTH-1:0] RxData;
  logic             RxWrite;
  logic             SSPRXINTR;
  logic             RxEmpty;
  logic             RxOverrun;

  modport master (
    output PSEL_RX, PWRITE_RX, RxData, RxWrite,
    input  PRDATA_RX, SSPRXINTR, RxEmpty, RxOverrun
  );

  modport slave (
    input  PSEL_RX, PWRITE_RX, RxData, RxWrite,
    output PRDATA_RX, SSPRXINTR, RxEmpty, RxOverrun
  );

endinterface
`default_nettype wire

// File: rtl/rx_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : rx_fifo_mem
// Brief    : DEPTH x WIDTH storage, synchronous write, asynchronous read.
// Revision : 1.0 - initial release
// ============================================================================
module rx_fifo_mem
  import rx_fifo_pkg::*;
#(
  parameter int WIDTH  = RX_FIFO_WIDTH,
  parameter int DEPTH  = RX_FIFO_DEPTH,
  parameter int ADDR_W = RX_FIFO_PTR_W
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]  i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // No reset: stale contents are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rx_fifo
// Brief    : SSP receive FIFO, pushed by the receiver and popped over APB.
// Revision : 1.0 - initial release
// ============================================================================
module rx_fifo
  import rx_fifo_pkg::*;
#(
  parameter int WIDTH = RX_FIFO_WIDTH,
  parameter int DEPTH = RX_FIFO_DEPTH
) (
  input  logic     PCLK_RX,
  input  logic     CLEAR_RX,
  rx_fifo_if.slave bus
);

  localparam int                 c_PTR_W   = rx_fifo_ptr_w(DEPTH);
  localparam int                 c_CNT_W   = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [WIDTH-1:0]   r_prdata;
  logic               r_overrun;

  logic               w_rd_req;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [WIDTH-1:0]   w_rd_data;

  assign w_rd_req = bus.PSEL_RX & ~bus.PWRITE_RX;
  assign w_pop    = w_rd_req & (r_count != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push   = bus.RxWrite & ((r_count != c_FULL) | w_pop);
  assign w_drop   = bus.RxWrite & ~w_push;

  rx_fifo_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (c_PTR_W)
  ) u_mem (
    .clk       (PCLK_RX),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (bus.RxData),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge PCLK_RX or posedge CLEAR_RX) begin
    if (CLEAR_RX) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_prdata  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_pop) begin
        r_prdata <= w_rd_data;
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.PRDATA_RX = r_prdata;
  assign bus.SSPRXINTR = (r_count == c_FULL);
  assign bus.RxEmpty   = (r_count == '0);
  assign bus.RxOverrun = r_overrun;

endmodule
`default_nettype wire

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits.
REQ-002 Parameter DEPTH, default 4: number of entries; power of two, at least 2.
REQ-003 PCLK_RX  input  1: single clock; all state updates on its rising edge.
REQ-004 CLEAR_RX  input  1: reset, asynchronous, active-high.
REQ-005 PSEL_RX  input  1: APB peripheral select for the receive FIFO.
REQ-006 PWRITE_RX  input  1: APB direction; 0 means read.
REQ-007 PRDATA_RX  output  WIDTH: registered APB read data, i.e. the popped entry.
REQ-008 RxData  input  WIDTH: received word from the SSP receive logic.
REQ-009 RxWrite  input  1: one-cycle push strobe qualifying RxData.
REQ-010 SSPRXINTR  output  1: receive interrupt; high while the FIFO is full.
REQ-011 RxEmpty  output  1: high while the FIFO holds 0 entries.
REQ-012 RxOverrun  output  1: sticky flag; high after a push was dropped.

Function
REQ-013 Storage: DEPTH x WIDTH circular buffer.
REQ-014 Pointers: read and write pointers of log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-015 Count: occupancy count of log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-016 Read request: rd_req = PSEL_RX & ~PWRITE_RX.
REQ-017 Push request: wr_req = RxWrite.
REQ-018 Pop: occurs when rd_req is high and count>0 at the edge; PRDATA_RX <= mem[rd_ptr]; rd_ptr advances by 1. Read latency is 1 cycle.
REQ-019 Read when empty: count=0 with rd_req high; no pop occurs, and PRDATA_RX, pointers and count hold.
REQ-020 Push: occurs when wr_req is high and (count<DEPTH or a pop occurs in the same cycle); mem[wr_ptr] <= RxData; wr_ptr advances by 1.
REQ-021 Push when full: count=DEPTH with no pop in the same cycle; the word is dropped and RxOverrun is set to 1.
REQ-022 RxOverrun stays set until reset.
REQ-023 Simultaneous push and pop: count is unchanged; the popped data is the old head entry.
REQ-024 Simultaneous push and pop when full: both are accepted; the FIFO stays full and no overrun is flagged.
REQ-025 Simultaneous push and pop when empty: only the push takes effect (no write-through bypass); count becomes 1 and PRDATA_RX holds.
REQ-026 Count update: count +1 on push only, -1 on pop only, unchanged otherwise.
REQ-027 SSPRXINTR = (count==DEPTH), decoded from the registered count.
REQ-028 RxEmpty = (count==0), decoded from the registered count.
REQ-029 Neither SSPRXINTR nor RxEmpty has a combinational path from any input.
REQ-030 PSEL_RX=1 with PWRITE_RX=1 has no effect on the block; the FIFO is read-only from APB.

Reset
REQ-031 While CLEAR_RX=1, asynchronously: rd_ptr=0, wr_ptr=0, count=0, PRDATA_RX=0, RxOverrun=0, SSPRXINTR=0, RxEmpty=1.
REQ-032 Reset asserted mid-operation discards all stored entries immediately; buffer contents need not be cleared.
REQ-033 The first push or pop is accepted at the first rising edge after CLEAR_RX falls.

Structure
REQ-034 Package rx_fifo_pkg holds the RX_FIFO_WIDTH and RX_FIFO_DEPTH defaults and the derived pointer and count widths.
REQ-035 The storage array is one sub-module, rx_fifo_mem: synchronous write, asynchronous read.
REQ-036 Pointer, count and flag logic sit in rx_fifo; total RTL stays within 120-400 lines.

Verification
REQ-037 Reset check: assert CLEAR_RX for 1 cycle.
- Required response: RxEmpty=1, SSPRXINTR=0, RxOverrun=0, PRDATA_RX=0x00.
REQ-038 Fill then drain: push 0x01,0x02,0x03,0x05, then read 4 times.
- After 4 pushes: SSPRXINTR=1.
- Reads: PRDATA_RX = 0x01,0x02,0x03,0x05, each 1 cycle after its read edge.
- Afterwards: RxEmpty=1.
REQ-039 Overrun: fill with 0x01..0x04, then push 0x06 with no read.
- RxOverrun=1 on the next cycle.
- Subsequent 4 reads return 0x01..0x04; 0x06 is never returned.
REQ-040 Full simultaneous: fill with 0x01..0x04, then read and push 0x09 in the same cycle.
- PRDATA_RX=0x01, SSPRXINTR stays 1, RxOverrun stays 0.
- Next 4 reads return 0x02,0x03,0x04,0x09.
REQ-041 Empty read and wrap:
- Read when empty: PRDATA_RX holds.
- Then 6 push/pop pairs of 0x10..0x15 wrap the pointers; data returns in order.
- Raise CLEAR_RX with 2 entries held: RxEmpty=1 immediately.
